// File: rtl/karatsuba_pkg.sv
// Shared widths and FSM state encodings for the Karatsuba multiply-accumulate stage.
package karatsuba_pkg;
    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/karatsuba_mult_16.sv
// Combinational 16x16 unsigned multiplier built from three 8/9-bit partial products.
module karatsuba_mult_16
    import karatsuba_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);
    logic [7:0]  a_hi, a_lo, b_hi, b_lo;
    logic [8:0]  a_sum, b_sum;
    logic [15:0] z2, z0;
    logic [17:0] zm, z1;

    assign a_hi  = a[15:8];
    assign a_lo  = a[7:0];
    assign b_hi  = b[15:8];
    assign b_lo  = b[7:0];
    assign a_sum = {1'b0, a_hi} + {1'b0, a_lo};
    assign b_sum = {1'b0, b_hi} + {1'b0, b_lo};

    assign z2 = {8'b0, a_hi} * {8'b0, b_hi};
    assign z0 = {8'b0, a_lo} * {8'b0, b_lo};
    assign zm = {9'b0, a_sum} * {9'b0, b_sum};
    // Middle term a_hi*b_lo + a_lo*b_hi never exceeds 17 bits, so 18-bit wrap is safe.
    assign z1 = zm - {2'b0, z2} - {2'b0, z0};

    assign p = {z2, 16'b0} + {6'b0, z1, 8'b0} + {16'b0, z0};
endmodule

// File: rtl/karatsuba_mac_16.sv
// Streaming MAC: operand register, product register, then accumulate; block result held
// on a valid/ready port until the consumer takes it.
module karatsuba_mac_16
    import karatsuba_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf
);
    state_t              state_q, state_d;
    logic                s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [OP_W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic                s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [PROD_W-1:0]   s2_prod_q, s2_prod_d, prod;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [ACC_W:0]      sum;
    logic                accept;

    karatsuba_mult_16 u_mult (
        .a (s1_x_q),
        .b (s1_y_q),
        .p (prod)
    );

    assign in_ready = !rst && (state_q == IDLE || state_q == ACCUM);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s2_prod_q};

    always_comb begin
        s1_valid_d = accept;
        s1_last_d  = accept ? in_last : s1_last_q;
        s1_x_d     = accept ? x : s1_x_q;
        s1_y_d     = accept ? y : s1_y_q;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_valid_q && s1_last_q;
        s2_prod_d  = s1_valid_q ? prod : s2_prod_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        state_d    = state_q;

        if (state_q == HOLD && acc_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (s2_valid_q) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE, ACCUM: if (accept) state_d = in_last ? DRAIN : ACCUM;
            DRAIN:       if (s2_valid_q && s2_last_q) state_d = HOLD;
            HOLD:        if (acc_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc_valid = (state_q == HOLD);
    assign acc_out   = acc_q;
    assign acc_count = cnt_q;
    assign acc_ovf   = ovf_q;
endmodule
